// File: rtl/bist_misr_checker_if.sv
// Handshake/bus bundle between the BIST controller side and the MISR checker.
// The controller (master) drives strobes and the CUT response bus; the
// checker (slave) returns the signature, cycle count and status flags.
interface bist_misr_checker_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 8
);
  logic             init;
  logic             running;
  logic             finish;
  logic [WIDTH-1:0] cut_out;
  logic [WIDTH-1:0] signature;
  logic [CW-1:0]    cycle_count;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;

  modport master (
    output init, running, finish, cut_out,
    input  signature, cycle_count, busy, done, pass, fail
  );

  modport slave (
    input  init, running, finish, cut_out,
    output signature, cycle_count, busy, done, pass, fail
  );
endinterface

// File: rtl/bist_misr_checker.sv
// BIST response compaction: folds CUT outputs into a Galois MISR while the
// controller reports running, then compares against GOLDEN on finish and
// holds pass/fail until the next init.
// Optional macro CYCLE_CHECK_EN: pass also requires cycle_count==EXP_CYCLES.
module bist_misr_checker #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = 16'h1021,
  parameter logic [WIDTH-1:0] SEED       = 16'h0000,
  parameter logic [WIDTH-1:0] GOLDEN     = 16'h0000,
  parameter int               EXP_CYCLES = 11,
  parameter int               CW         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  bist_misr_checker_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARMED, COMPRESS, DONE} state_t;

`ifdef CYCLE_CHECK_EN
  localparam logic CHECK_CNT = 1'b1;
`else
  localparam logic CHECK_CNT = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sig, sig_step, sig_post;
  logic [CW-1:0]    cnt, cnt_post;
  logic             res_pass;
  logic             active, compress, restart, compare, match;

  // One MISR step: shift, fold the outgoing MSB through the taps, mix in data
  assign sig_step = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ bus.cut_out;

  assign active   = (state == ARMED) || (state == COMPRESS);
  // init restarts from any state and overrides running/finish on that edge
  assign restart  = bus.init;
  assign compress = active && !restart && bus.running;
  assign compare  = active && !restart && bus.finish;

  // Compare sees this cycle's data when finish coincides with running
  assign sig_post = compress ? sig_step : sig;
  assign cnt_post = (compress && (cnt != '1)) ? cnt + 1'b1 : cnt;
  assign match    = (sig_post == GOLDEN) &&
                    (!CHECK_CNT || (cnt_post == CW'(EXP_CYCLES)));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    if (restart)          state_nxt = ARMED;
    else case (state)
      ARMED:    if (bus.finish)       state_nxt = DONE;
                else if (bus.running) state_nxt = COMPRESS;
      COMPRESS: if (bus.finish)       state_nxt = DONE;
      default:  state_nxt = state;
    endcase
  end

  // Signature, saturating cycle counter and latched compare result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig      <= SEED;
      cnt      <= '0;
      res_pass <= 1'b0;
    end else if (restart) begin
      sig      <= SEED;
      cnt      <= '0;
      res_pass <= 1'b0;
    end else begin
      sig <= sig_post;
      cnt <= cnt_post;
      if (compare) res_pass <= match;
    end
  end

  // Status outputs; pass/fail only meaningful while in DONE
  always_comb begin
    bus.busy = active;
    bus.done = (state == DONE);
    bus.pass = (state == DONE) &&  res_pass;
    bus.fail = (state == DONE) && !res_pass;
  end

  assign bus.signature   = sig;
  assign bus.cycle_count = cnt;

endmodule

// File: tb/tb_bist_misr_checker.sv
// Directed bench for bist_misr_checker. Three instances share one stimulus:
// a: SEED 0, GOLDEN 2 (main table), b: SEED 8000, GOLDEN 0,
// c: SEED 0, GOLDEN 1, CW 2 (coincident finish and counter saturation).
module tb_bist_misr_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0, running = 1'b0, finish = 1'b0;
  logic [15:0] cut = '0;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  bist_misr_checker_if #(.WIDTH(16), .CW(8)) ia ();
  bist_misr_checker_if #(.WIDTH(16), .CW(8)) ib ();
  bist_misr_checker_if #(.WIDTH(16), .CW(2)) ic ();

  assign ia.init = init;  assign ia.running = running;
  assign ia.finish = finish;  assign ia.cut_out = cut;
  assign ib.init = init;  assign ib.running = running;
  assign ib.finish = finish;  assign ib.cut_out = cut;
  assign ic.init = init;  assign ic.running = running;
  assign ic.finish = finish;  assign ic.cut_out = cut;

  bist_misr_checker #(.WIDTH(16), .POLY(16'h1021), .SEED(16'h0000),
    .GOLDEN(16'h0002), .EXP_CYCLES(2), .CW(8))
    u_a (.clk(clk), .reset(rst_n), .bus(ia.slave));
  bist_misr_checker #(.WIDTH(16), .POLY(16'h1021), .SEED(16'h8000),
    .GOLDEN(16'h0000), .EXP_CYCLES(1), .CW(8))
    u_b (.clk(clk), .reset(rst_n), .bus(ib.slave));
  bist_misr_checker #(.WIDTH(16), .POLY(16'h1021), .SEED(16'h0000),
    .GOLDEN(16'h0001), .EXP_CYCLES(2), .CW(2))
    u_c (.clk(clk), .reset(rst_n), .bus(ic.slave));

  typedef struct {
    logic        i, r, f;
    logic [15:0] cut;
    logic [15:0] sig;
    logic [7:0]  cnt;
    logic [3:0]  flg;   // {busy, done, pass, fail} of instance a
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic i, r, f, input logic [15:0] c,
                     input logic [15:0] s, input logic [7:0] n, input logic [3:0] fl);
    vec_t v;
    v.i = i; v.r = r; v.f = f; v.cut = c; v.sig = s; v.cnt = n; v.flg = fl;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge take it, sample 1 time unit later
  task automatic step(input logic i, r, f, input logic [15:0] c);
    @(negedge clk);
    init = i; running = r; finish = f; cut = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags_a();
    return {ia.busy, ia.done, ia.pass, ia.fail};
  endfunction

  initial begin
    // idle ignores running/finish
    add(0,1,1,16'hFFFF, 16'h0000, 8'd0, 4'b0000);
    // basic run: data 1 then 0 -> signature 2, pass
    add(1,0,0,16'h0000, 16'h0000, 8'd0, 4'b1000);
    add(0,1,0,16'h0001, 16'h0001, 8'd1, 4'b1000);
    add(0,0,0,16'h00AA, 16'h0001, 8'd1, 4'b1000);   // stall holds
    add(0,1,0,16'h0000, 16'h0002, 8'd2, 4'b1000);
    add(0,0,1,16'h0000, 16'h0002, 8'd2, 4'b0110);
    add(0,1,0,16'h0007, 16'h0002, 8'd2, 4'b0110);   // DONE holds result
    // re-arm clears result; 3 cycles of 5, then restart via init+finish
    add(1,0,0,16'h0000, 16'h0000, 8'd0, 4'b1000);
    add(0,1,0,16'h0005, 16'h0005, 8'd1, 4'b1000);
    add(0,1,0,16'h0005, 16'h000F, 8'd2, 4'b1000);
    add(0,1,0,16'h0005, 16'h001B, 8'd3, 4'b1000);
    add(1,0,1,16'h0000, 16'h0000, 8'd0, 4'b1000);   // init beats finish
    for (int k = 1; k <= 11; k++) add(0,1,0,16'h0000, 16'h0000, 8'(k), 4'b1000);
    add(0,0,1,16'h0000, 16'h0000, 8'd11, 4'b0101);  // sig 0 != golden 2
    // finish straight from ARMED
    add(1,0,0,16'h0000, 16'h0000, 8'd0, 4'b1000);
    add(0,0,1,16'h0000, 16'h0000, 8'd0, 4'b0101);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sig_a", ia.signature, 16'h0000);
    chk("rst_sig_b", ib.signature, 16'h8000);
    chk("rst_cnt_a", ia.cycle_count, 0);
    chk("rst_flags_a", flags_a(), 4'b0000);
    chk("rst_flags_b", {ib.busy, ib.done, ib.pass, ib.fail}, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    step(0,0,0,16'h0000);
    chk("idle_hold_flags", flags_a(), 4'b0000);

    foreach (tbl[n]) begin
      step(tbl[n].i, tbl[n].r, tbl[n].f, tbl[n].cut);
      chk($sformatf("v%0d_sig", n), ia.signature, tbl[n].sig);
      chk($sformatf("v%0d_cnt", n), ia.cycle_count, tbl[n].cnt);
      chk($sformatf("v%0d_flags", n), flags_a(), tbl[n].flg);
    end

    // seed 8000 through one zero cycle -> 1021, fails against golden 0
    step(1,0,0,16'h0000);
    chk("seed_load_b", ib.signature, 16'h8000);
    step(0,1,0,16'h0000);
    chk("seed_step_b", ib.signature, 16'h1021);
    step(0,0,1,16'h0000);
    chk("seed_flags_b", {ib.busy, ib.done, ib.pass, ib.fail}, 4'b0101);

    // finish coinciding with running includes that cycle's data
    step(1,0,0,16'h0000);
    step(0,1,0,16'h0000);
    step(0,1,1,16'h0001);
    chk("coinc_sig_c", ic.signature, 16'h0001);
    chk("coinc_cnt_c", ic.cycle_count, 2);
    chk("coinc_flags_c", {ic.busy, ic.done, ic.pass, ic.fail}, 4'b0110);
    chk("coinc_flags_a", flags_a(), 4'b0101);

    // saturation of the 2-bit counter
    step(1,0,0,16'h0000);
    repeat (5) step(0,1,0,16'h0000);
    chk("sat_cnt_c", ic.cycle_count, 3);
    chk("sat_cnt_a", ia.cycle_count, 5);

    // asynchronous reset mid-compression
    step(1,0,0,16'h0000);
    step(0,1,0,16'h0001);
    step(0,1,0,16'h0001);
    chk("pre_rst_sig_a", ia.signature, 16'h0003);
    @(negedge clk);
    running = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_sig_a", ia.signature, 16'h0000);
    chk("async_cnt_a", ia.cycle_count, 0);
    chk("async_flags_a", flags_a(), 4'b0000);
    chk("async_sig_b", ib.signature, 16'h8000);
    @(negedge clk) rst_n = 1'b1;
    step(0,0,1,16'h0000);
    chk("idle_finish_flags_a", flags_a(), 4'b0000);
    step(0,0,0,16'h0000);
    chk("idle_finish_done_b", ib.done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
